// File: rtl/il1_refill_responder.sv
// il1_refill_responder
// L2-side responder for instruction L1 miss refills plus the inclusive
// back-invalidation handshake toward the IL1. Two small FSMs share one clock:
// the refill FSM (read line from L2, present it to IL1) and the eviction FSM
// (ask IL1 to drop a set index on L2 eviction). They are interlocked so that
// update and inst_replace_sync are never high together.
//
// Handshake semantics:
//   update_trigger : single-cycle request, only honoured in R_IDLE.
//   l2_rd_req/valid: l2_rd_req is a level held through R_READ; l2_rd_valid is a
//                    one-cycle data strobe, ignored outside R_READ.
//   evict_req/ack  : L2 holds evict_req until it sees the one-cycle evict_ack.
//   sync/solve     : inst_replace_sync is a level held (index stable) until
//                    inst_replace_solve is sampled high, then drops for at
//                    least one cycle before another eviction may start.
module il1_refill_responder #(
  parameter int PC_LENGTH   = 32,
  parameter int INST_LENGTH = 32,
  parameter int LINE_WORDS  = 4,
  parameter int ICACHE_LINE = 128,
  parameter int UPD_CYCLES  = 4
) (
  input  logic                                 clk_l2,
  input  logic                                 rst,
  input  logic                                 update_trigger,
  input  logic [PC_LENGTH-1:0]                 pc_up,
  output logic                                 l2_rd_req,
  output logic [PC_LENGTH-1:0]                 l2_rd_addr,
  input  logic                                 l2_rd_valid,
  input  logic [LINE_WORDS*INST_LENGTH-1:0]    l2_rd_data,
  output logic                                 update,
  output logic [LINE_WORDS*INST_LENGTH-1:0]    update_line,
  output logic [INST_LENGTH-1:0]               update_inst,
  input  logic                                 evict_req,
  input  logic [$clog2(ICACHE_LINE)-1:0]       evict_index,
  output logic                                 evict_ack,
  output logic                                 inst_replace_sync,
  output logic [$clog2(ICACHE_LINE)-1:0]       inst_index_inclusive,
  input  logic                                 inst_replace_solve,
  output logic                                 busy,
  output logic                                 protocol_err,
  output logic [2:0]                           r_state_dbg,
  output logic [1:0]                           x_state_dbg
);

  localparam int WOFF   = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(ICACHE_LINE);
  localparam int LINE_W = LINE_WORDS * INST_LENGTH;
  localparam int ALIGN  = WOFF + 2;
  localparam int CNT_W  = $clog2(UPD_CYCLES + 1);

  typedef enum logic [2:0] {
    R_IDLE   = 3'd0,
    R_READ   = 3'd1,
    R_HOLD   = 3'd2,
    R_UPDATE = 3'd3,
    R_GAP    = 3'd4
  } r_state_t;

  typedef enum logic [1:0] {
    X_IDLE    = 2'd0,
    X_SYNC    = 2'd1,
    X_RELEASE = 2'd2
  } x_state_t;

  r_state_t              r_state_q, r_state_d;
  x_state_t              x_state_q, x_state_d;
  logic [PC_LENGTH-1:0]  pc_q, pc_d;
  logic [PC_LENGTH-1:0]  rd_addr_q, rd_addr_d;
  logic                  rd_req_q, rd_req_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [INST_LENGTH-1:0] inst_q, inst_d;
  logic                  upd_q, upd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  perr_q, perr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ack_q, ack_d;
  logic                  sync_q, sync_d;

  logic                  enter_update;
  logic                  evict_ok;
  logic [WOFF-1:0]       word_sel;
  logic [INST_LENGTH-1:0] inst_sel;

  // The critical word is chosen by the latched miss PC, not the live pc_up.
  assign word_sel = pc_q[WOFF+1:2];

  // Critical-word mux over the incoming L2 line.
  always_comb begin
    inst_sel = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      if (word_sel == WOFF'(w)) begin
        inst_sel = l2_rd_data[w*INST_LENGTH +: INST_LENGTH];
      end
    end
  end

  // Next-state logic for both FSMs; the refill side is resolved first so the
  // eviction side can see whether the refill is about to start presenting data.
  always_comb begin
    r_state_d    = r_state_q;
    x_state_d    = x_state_q;
    pc_d         = pc_q;
    rd_addr_d    = rd_addr_q;
    rd_req_d     = rd_req_q;
    line_d       = line_q;
    inst_d       = inst_q;
    upd_d        = upd_q;
    cnt_d        = cnt_q;
    perr_d       = perr_q;
    idx_d        = idx_q;
    sync_d       = sync_q;
    ack_d        = 1'b0;
    enter_update = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        if (update_trigger) begin
          pc_d      = pc_up;
          rd_addr_d = {pc_up[PC_LENGTH-1:ALIGN], {ALIGN{1'b0}}};
          rd_req_d  = 1'b1;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        if (l2_rd_valid) begin
          line_d   = l2_rd_data;
          inst_d   = inst_sel;
          rd_req_d = 1'b0;
          if (x_state_q == X_IDLE) begin
            enter_update = 1'b1;
          end else begin
            r_state_d = R_HOLD;
          end
        end
      end
      R_HOLD: begin
        // Only present the line once no invalidation is in flight.
        if (x_state_q == X_IDLE) begin
          enter_update = 1'b1;
        end
      end
      R_UPDATE: begin
        if (cnt_q == '0) begin
          upd_d     = 1'b0;
          r_state_d = R_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      R_GAP: begin
        r_state_d = R_IDLE;
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase

    if (enter_update) begin
      r_state_d = R_UPDATE;
      upd_d     = 1'b1;
      cnt_d     = CNT_W'(UPD_CYCLES - 1);
    end

    if (update_trigger && (r_state_q != R_IDLE)) begin
      perr_d = 1'b1;
    end

    busy_d = (r_state_d != R_IDLE);

    // Refill wins a same-cycle conflict; evictions are also kept out of the
    // whole update window and its trailing gap cycle.
    evict_ok = ((r_state_q == R_IDLE) || (r_state_q == R_READ) ||
                (r_state_q == R_HOLD)) && !enter_update;

    case (x_state_q)
      X_IDLE: begin
        if (evict_req && evict_ok) begin
          idx_d     = evict_index;
          ack_d     = 1'b1;
          sync_d    = 1'b1;
          x_state_d = X_SYNC;
        end
      end
      X_SYNC: begin
        if (inst_replace_solve) begin
          sync_d    = 1'b0;
          x_state_d = X_RELEASE;
        end
      end
      X_RELEASE: begin
        x_state_d = X_IDLE;
      end
      default: begin
        x_state_d = X_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any refill or eviction at once.
  always_ff @(posedge clk_l2 or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      x_state_q <= X_IDLE;
      pc_q      <= '0;
      rd_addr_q <= '0;
      rd_req_q  <= 1'b0;
      line_q    <= '0;
      inst_q    <= '0;
      upd_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      idx_q     <= '0;
      ack_q     <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      x_state_q <= x_state_d;
      pc_q      <= pc_d;
      rd_addr_q <= rd_addr_d;
      rd_req_q  <= rd_req_d;
      line_q    <= line_d;
      inst_q    <= inst_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      perr_q    <= perr_d;
      idx_q     <= idx_d;
      ack_q     <= ack_d;
      sync_q    <= sync_d;
    end
  end

  assign l2_rd_req            = rd_req_q;
  assign l2_rd_addr           = rd_addr_q;
  assign update               = upd_q;
  assign update_line          = line_q;
  assign update_inst          = inst_q;
  assign evict_ack            = ack_q;
  assign inst_replace_sync    = sync_q;
  assign inst_index_inclusive = idx_q;
  assign busy                 = busy_q;
  assign protocol_err         = perr_q;
  assign r_state_dbg          = r_state_q;
  assign x_state_dbg          = x_state_q;

endmodule
